serial_rx: RTL
==============

# serial_rx

Serial receiver for the one-wire link driven by the `control` transmitter. It recovers each 4-bit switch frame and presents it as a parallel word for the LED/display side. It oversamples the line with `sysclk` and samples each bit at mid-bit. Good frames are flagged with a one-cycle `valid` pulse; malformed frames are flagged with a one-cycle `frame_err` pulse.

## Interface
- `BIT_CYCLES`, 5000, `sysclk` cycles per bit on the line; even, ≥ 8.
- `HALF`, `BIT_CYCLES/2`, start-bit confirmation point; derived, not overridden.
- `sysclk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  serial line (the transmitter's `out`); idles high; asynchronous to frame timing.
- `data`  out  4  last good frame: `data[0]` = sw1 … `data[3]` = sw4.
- `valid`  out  1  one-cycle pulse when `data` has been updated.
- `frame_err`  out  1  one-cycle pulse when the stop bit was sampled low.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Frame format, fixed:
  - start bit = 0
  - 4 data bits, sw1 first (LSB first)
  - stop bit = 1
  - each bit lasts `BIT_CYCLES` cycles
  - any idle length between frames, including zero
- `rx` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- Bit counter `cnt` is `$clog2(BIT_CYCLES)` bits wide. It clears on every state change and never wraps inside a state.
- Index `idx` is 2 bits. Shift register `sh` is 4 bits.
- States:
  - IDLE: if `rx_s==0`, go to START, `cnt=0`.
  - START: when `cnt==HALF-1`:
    - `rx_s==0`: go to DATA, `idx=0`.
    - `rx_s==1`: glitch; return to IDLE with no error.
  - DATA: when `cnt==BIT_CYCLES-1`, set `sh[idx]=rx_s`.
    - `idx==3`: go to STOP.
    - otherwise `idx++`.
  - STOP: when `cnt==BIT_CYCLES-1`:
    - `rx_s==1`: `data<=sh`, `valid=1` for one cycle, go to IDLE.
    - `rx_s==0`: `frame_err=1` for one cycle, `data` unchanged, go to BREAK.
  - BREAK: stay until `rx_s==1`, then go to IDLE. No new frame can start while the line is held low.
- `busy` is registered and reflects the current state: it equals `(state != IDLE)`.
- `valid` and `frame_err` are never high in the same cycle.
- Reset values: `data=4'h0`, `valid=0`, `frame_err=0`, `busy=0`, state IDLE, `cnt=0`, `idx=0`, `sh=0`, synchronizer flops = 1.
- `rst` mid-frame aborts immediately: no `valid` and no `frame_err` for the aborted frame. `rst` has priority over every transition.

## Timing
- Edge numbering: edge 1 is the first `sysclk` edge at which `rx` is low.
  - `rx_s` is low after edge 2.
  - START is entered at edge 3.
  - DATA is entered at edge 3+HALF.
- Bit k (k = 0..3) is sampled at edge 3+HALF+(k+1)·BIT_CYCLES. This is mid-bit, ±1 cycle.
- STOP is sampled at edge 3+HALF+5·BIT_CYCLES. `valid`/`frame_err` are high in the following cycle.
- With `BIT_CYCLES=16`, this is edge 91.
- Back-to-back frames: IDLE is re-entered one cycle after the stop sample, about HALF cycles before the next start edge, so there is no frame loss.
- A start edge arriving while already in IDLE is accepted with no extra delay.
- Glitch rejection: a low pulse shorter than HALF−1 cycles never reaches DATA. `busy` returns to 0 within HALF+3 cycles of the pulse start.

## Test plan
All cases use `BIT_CYCLES=16`.
- **Reset:** hold `rst` 5 cycles with `rx=1` -> `data=0`, `valid=0`, `frame_err=0`, `busy=0`, held for 200 idle cycles.
- **Single frame:** frame sw1..sw4 = 1,0,1,0 -> exactly one `valid` pulse at edge 91, `data=4'h5`, `busy` low the cycle after.
- **Back-to-back:** frame 4'hF immediately followed by 4'h0 (zero idle) -> two `valid` pulses 96 cycles apart, `data` 4'hF then 4'h0, no `frame_err`.
- **Glitch:** `rx` low for 3 cycles then high -> no `valid`, no `frame_err`, `busy` low again by cycle 11.
- **Break:** start + data 4'h3, then `rx` held low 100 cycles -> one `frame_err` pulse at edge 91, `data` keeps its previous value, `busy` stays high until 2 cycles after `rx` rises; a following good frame 4'h9 is received.
- **Mid-frame reset:** assert `rst` for 1 cycle during DATA bit 2 -> `busy=0` the next cycle, no pulse for the aborted frame, `data=0`; the next frame 4'hA yields `valid` with `data=4'hA`.

Source files
------------

// File: rtl/serial_rx.sv
// serial_rx: one-wire 4-bit frame receiver with mid-bit sampling, glitch rejection and break detection
module serial_rx #(
  parameter int BIT_CYCLES = 5000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int HALF = BIT_CYCLES / 2;
  localparam int CW = $clog2(BIT_CYCLES);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [3:0] sh;
  logic rx_m, rx_s;
  logic bit_end, half_end, smp, ok, err;
  // state, timing counters, synchronizer and registered outputs
  always_ff @(posedge sysclk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      data <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      state <= nxt;
      cnt <= (nxt != state || smp || state == IDLE || state == BRK) ? '0 : cnt + CW'(1);
      idx <= state == DATA ? idx + 2'(smp) : 2'd0;
      if (smp) sh[idx] <= rx_s;
      if (ok) data <= sh;
      valid <= ok;
      frame_err <= err;
      busy <= nxt != IDLE;
    end
  end
  // next-state selection
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (!rx_s) nxt = START;
      START: if (half_end) nxt = rx_s ? IDLE : DATA;
      DATA: if (bit_end && idx == 2'd3) nxt = STOP;
      STOP: if (bit_end) nxt = rx_s ? IDLE : BRK;
      BRK: if (rx_s) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // per-state decode of bit boundaries, data samples and frame verdicts
  always_comb begin
    bit_end = cnt == CW'(BIT_CYCLES - 1);
    half_end = cnt == CW'(HALF - 1);
    smp = state == DATA && bit_end;
    ok = state == STOP && bit_end && rx_s;
    err = state == STOP && bit_end && !rx_s;
  end
endmodule
